// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO constants: default data/counter widths and the depth of the
// read-side output buffer.
package fifo_rd_ctrl_pkg;

  localparam int unsigned FIFO_FW       = 8;
  localparam int unsigned FIFO_CW       = 16;
  localparam int unsigned OUT_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues reads, buffers returning words in a
// 2-entry in-order skid buffer and delivers them over valid/ready.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned FW = FIFO_FW,
  parameter int unsigned CW = FIFO_CW
) (
  input  logic          r_clk,
  input  logic          rst,
  input  logic          en,
  input  logic          empty,
  input  logic [FW-1:0] rdata,
  output logic          rd,
  output logic [FW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] word_cnt,
  output logic [FW-1:0] sum
);

  localparam logic [1:0] OCC_FULL = 2'(OUT_BUF_DEPTH);

  logic [FW-1:0] head;
  logic [FW-1:0] tail;
  logic [1:0]    occ;
  logic          pend;
  logic          pop;
  logic [2:0]    fill;

  assign out_valid = (occ != 2'd0) && !rst;
  assign out_data  = head;
  assign pop       = out_valid && out_ready;

  // Occupancy once the in-flight word lands and this cycle's pop retires;
  // a pop implies occ >= 1, so the subtraction cannot underflow.
  assign fill = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  assign rd   = !rst && en && !empty && (fill <= 3'd1);

  always_ff @(posedge r_clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      pend     <= 1'b0;
      word_cnt <= '0;
      sum      <= '0;
    end else begin
      pend <= rd;
      if (pop) begin
        word_cnt <= word_cnt + CW'(1);
        sum      <= sum + head;
      end
      unique case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) head <= rdata;
          else             tail <= rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == OCC_FULL) head <= tail;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous write and pop: occupancy is unchanged, entries shift.
          if (occ == OCC_FULL) begin
            head <= tail;
            tail <= rdata;
          end else begin
            head <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO model plus an in-order scoreboard
// of words loaded into the FIFO, checked against delivered words.
module tb_fifo_rd_ctrl;

  localparam int unsigned FW = 8;
  localparam int unsigned CW = 4;

  logic          r_clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          empty;
  logic [FW-1:0] rdata = '0;
  logic          rd;
  logic [FW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] word_cnt;
  logic [FW-1:0] sum;

  fifo_rd_ctrl #(.FW(FW), .CW(CW)) dut (
    .r_clk    (r_clk),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .rdata    (rdata),
    .rd       (rd),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .word_cnt (word_cnt),
    .sum      (sum)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: data appears on rdata one cycle after rd; flushed by reset.
  logic [FW-1:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (rd && !empty) begin
      rdata  <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle-time %0t", tag, act, exp, $time);
    else
      passed++;
  endtask

  logic [FW-1:0] sb[$];
  int            cyc = 0;
  int            rd_cnt, first_rd, last_rd;
  int            val_cnt, first_val, last_val;
  int            max_occ;
  int            exp_cnt, exp_sum;
  logic          stall_prev = 1'b0;
  logic [FW-1:0] held = '0;

  task automatic clear_track();
    rd_cnt = 0; first_rd = -1; last_rd = -1;
    val_cnt = 0; first_val = -1; last_val = -1;
    max_occ = 0;
  endtask

  // Samples the DUT on the falling edge, then advances to just after the next rising edge.
  task automatic cycle();
    logic [FW-1:0] e;
    @(negedge r_clk);
    if (empty) check("rd_while_empty", 32'(rd), 32'd0);
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
    if (stall_prev && out_valid) check("hold_data", 32'(out_data), 32'(held));
    stall_prev = out_valid && !out_ready;
    held = out_data;
    if (out_valid && out_ready) begin
      val_cnt++;
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e));
        exp_cnt++;
        exp_sum += int'(e);
      end
    end
    @(posedge r_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    sb.delete();
    exp_cnt = 0;
    exp_sum = 0;
    stall_prev = 1'b0;
    rst = 1'b0;
    cycle();
    clear_track();
  endtask

  task automatic load(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = FW'(base + i * step);
      sb.push_back(FW'(base + i * step));
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
    check(tag, 32'(sb.size()), 32'd0);
    repeat (3) cycle();
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_word_cnt"}, 32'(word_cnt), 32'(exp_cnt % (1 << CW)));
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum % (1 << FW)));
  endtask

  int rd_before;

  initial begin
    #1;
    clear_track();
    do_reset();

    // Streaming 0..7
    load(8, 0, 1);
    en = 1'b1; out_ready = 1'b1;
    drain("stream_drain", 60);
    check("stream_rd_cnt", 32'(rd_cnt), 32'd8);
    check("stream_rd_consec", 32'(last_rd - first_rd), 32'd7);
    check("stream_latency", 32'(first_val - first_rd), 32'd2);
    check("stream_out_consec", 32'(last_val - first_val), 32'd7);
    check("stream_word_cnt", 32'(word_cnt), 32'd8);
    check("stream_sum", 32'(sum), 32'd28);
    check("stream_idle_valid", 32'(out_valid), 32'd0);

    // Backpressure for 5 cycles once word 2 is presented
    do_reset();
    load(8, 0, 1);
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && !(out_valid && out_data == FW'(2)); i++) cycle();
    check("bp_word2_seen", 32'(out_valid && out_data == FW'(2)), 32'd1);
    out_ready = 1'b0;
    rd_before = rd_cnt;
    repeat (5) cycle();
    check("bp_stall_rd", 32'(rd_cnt - rd_before), 32'd0);
    check("bp_occ_max", 32'(max_occ), 32'd2);
    check("bp_stall_data", 32'(out_data), 32'd2);
    out_ready = 1'b1;
    drain("bp_drain", 60);
    check("bp_rd_cnt", 32'(rd_cnt), 32'd8);
    check("bp_word_cnt", 32'(word_cnt), 32'd8);
    check("bp_sum", 32'(sum), 32'd28);

    // Empty boundary: only 3 words available
    do_reset();
    load(3, 10, 1);
    en = 1'b1; out_ready = 1'b1;
    drain("empty_drain", 40);
    repeat (4) cycle();
    check("empty_rd_cnt", 32'(rd_cnt), 32'd3);
    check("empty_out_valid", 32'(out_valid), 32'd0);
    check("empty_word_cnt", 32'(word_cnt), 32'd3);
    check("empty_sum", 32'(sum), 32'd33);

    // Enable drop after two read cycles, then resume
    do_reset();
    load(8, 20, 1);
    en = 1'b1; out_ready = 1'b1;
    cycle();
    cycle();
    en = 1'b0;
    repeat (8) cycle();
    check("endrop_rd_cnt", 32'(rd_cnt), 32'd2);
    check("endrop_word_cnt", 32'(word_cnt), 32'd2);
    check("endrop_out_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    drain("endrop_drain", 60);
    check("endrop_rd_total", 32'(rd_cnt), 32'd8);
    check_totals("endrop");

    // Reset while a word is buffered and another is in flight
    do_reset();
    load(8, 60, 1);
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && !(dut.pend && dut.occ != 2'd0); i++) cycle();
    check("midrst_state", 32'(dut.pend && dut.occ != 2'd0), 32'd1);
    do_reset();
    load(4, 40, 1);
    en = 1'b1; out_ready = 1'b1;
    drain("midrst_drain", 40);
    check("midrst_word_cnt", 32'(word_cnt), 32'd4);
    check("midrst_sum", 32'(sum), 32'd166);

    // Counter wrap with CW=4: 17 words of 0xFF
    do_reset();
    load(17, 255, 0);
    en = 1'b1; out_ready = 1'b1;
    drain("wrap_drain", 80);
    check("wrap_word_cnt", 32'(word_cnt), 32'd1);
    check("wrap_sum", 32'(sum), 32'hEF);
    check_totals("wrap");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
